// File: rtl/washer_pkg.sv
// Shared types for the laundry-cycle sequencer: state and phase encodings,
// actuator bit positions and the state-to-actuator map.
package washer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WASH,
    S_RINSE,
    S_DRAIN,
    S_DRY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_WASH,
    PH_RINSE,
    PH_ABORT
  } phase_t;

  localparam int ACT_FILL  = 0;
  localparam int ACT_WASH  = 1;
  localparam int ACT_RINSE = 2;
  localparam int ACT_DRAIN = 3;
  localparam int ACT_DRY   = 4;
  localparam int ACT_W     = 5;

  localparam int CNT_W = 4;

  function automatic logic [ACT_W-1:0] act_onehot(input state_t s);
    logic [ACT_W-1:0] v;
    v = '0;
    case (s)
      S_FILL:  v[ACT_FILL]  = 1'b1;
      S_WASH:  v[ACT_WASH]  = 1'b1;
      S_RINSE: v[ACT_RINSE] = 1'b1;
      S_DRAIN: v[ACT_DRAIN] = 1'b1;
      S_DRY:   v[ACT_DRY]   = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/washer_timer.sv
// Down-counting phase timer: load wins over count; expire flags the last
// unpaused cycle of a timed state.
module washer_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic [TIMER_W-1:0] count,
  output logic               expire
);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign expire = en && (count == TIMER_W'(1));

endmodule

// File: rtl/washer_seq_ctrl.sv
// Laundry-cycle sequencer: fill/wash/drain passes, configurable rinses, dry with
// wet extension, pause freeze and abort-to-drain, all timed by one shared timer.
module washer_seq_ctrl
  import washer_pkg::*;
#(
  parameter int N_SIZES     = 4,
  parameter int SIZE_W      = 2,
  parameter int TIMER_W     = 8,
  parameter int FILL_TICKS  = 2,
  parameter int WASH_TICKS  = 4,
  parameter int RINSE_TICKS = 3,
  parameter int DRAIN_TICKS = 2,
  parameter int DRY_TICKS   = 5,
  parameter int MAX_WASH    = 2,
  parameter int MAX_RINSE   = 3,
  parameter int MAX_DRY_EXT = 1
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              start,
  input  logic [SIZE_W-1:0] load_size,
  input  logic [1:0]        rinse_cfg,
  input  logic              dirty,
  input  logic              wet,
  input  logic              pause,
  input  logic              abort,
  output logic [SIZE_W-1:0] size_o,
  output logic              fill,
  output logic              wash,
  output logic              rinse,
  output logic              drain,
  output logic              dry,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              bad_size
);

  localparam longint TMAX = (longint'(1) << TIMER_W) - 1;

  if (N_SIZES < 1 || N_SIZES > (1 << SIZE_W) || MAX_RINSE > 3 || MAX_WASH < 1 ||
      MAX_WASH >= (1 << CNT_W) || MAX_DRY_EXT >= (1 << CNT_W) ||
      longint'(FILL_TICKS) * N_SIZES > TMAX || WASH_TICKS > TMAX || RINSE_TICKS > TMAX ||
      DRAIN_TICKS > TMAX || DRY_TICKS > TMAX) begin : g_bad_params
    $error("washer_seq_ctrl: parameter set out of range");
  end

  localparam logic [CNT_W-1:0]   MAX_WASH_C  = CNT_W'(MAX_WASH);
  localparam logic [CNT_W-1:0]   MAX_EXT_C   = CNT_W'(MAX_DRY_EXT);
  localparam logic [1:0]         MAX_RINSE_C = 2'(MAX_RINSE);
  localparam logic [SIZE_W:0]    SIZE_LIM    = (SIZE_W+1)'(N_SIZES);
  localparam logic [TIMER_W-1:0] WASH_T      = TIMER_W'(WASH_TICKS);
  localparam logic [TIMER_W-1:0] RINSE_T     = TIMER_W'(RINSE_TICKS);
  localparam logic [TIMER_W-1:0] DRAIN_T     = TIMER_W'(DRAIN_TICKS);
  localparam logic [TIMER_W-1:0] DRY_T       = TIMER_W'(DRY_TICKS);

  function automatic logic [TIMER_W-1:0] fill_len(input logic [SIZE_W-1:0] sz);
    return TIMER_W'(FILL_TICKS) * (TIMER_W'(sz) + TIMER_W'(1));
  endfunction

  state_t             state, state_nxt;
  phase_t             phase, phase_nxt;
  logic [SIZE_W-1:0]  size_nxt;
  logic [1:0]         rinse_l, rinse_l_nxt, rinse_n, rinse_nxt;
  logic [CNT_W-1:0]   wash_n, wash_nxt, ext_n, ext_nxt;
  logic               aborted_nxt, bad_nxt;
  logic [ACT_W-1:0]   act;
  logic               tmr_load, tmr_exp, tmr_zero;
  logic [TIMER_W-1:0] tmr_val, tmr_count;

  washer_timer #(.TIMER_W(TIMER_W)) u_timer (
    .Clk      (Clk),
    .nReset   (nReset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (!pause),
    .count    (tmr_count),
    .expire   (tmr_exp)
  );

  // An empty timer in a timed state (zero-tick parameter) is treated as expiry so it cannot hang.
  assign tmr_zero = (tmr_count == '0) && !pause;

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    size_nxt    = size_o;
    rinse_l_nxt = rinse_l;
    rinse_nxt   = rinse_n;
    wash_nxt    = wash_n;
    ext_nxt     = ext_n;
    aborted_nxt = 1'b0;
    bad_nxt     = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    if (state == S_IDLE) begin
      if (start) begin
        if ({1'b0, load_size} < SIZE_LIM) begin
          state_nxt   = S_FILL;
          phase_nxt   = PH_WASH;
          size_nxt    = load_size;
          rinse_l_nxt = (rinse_cfg > MAX_RINSE_C) ? MAX_RINSE_C : rinse_cfg;
          rinse_nxt   = '0;
          wash_nxt    = CNT_W'(1);
          ext_nxt     = '0;
          tmr_load    = 1'b1;
          tmr_val     = fill_len(load_size);
        end else begin
          bad_nxt = 1'b1;
        end
      end
    end else if (state == S_DONE) begin
      state_nxt = S_IDLE;
    end else if (abort && phase != PH_ABORT) begin
      state_nxt = S_DRAIN;
      phase_nxt = PH_ABORT;
      tmr_load  = 1'b1;
      tmr_val   = DRAIN_T;
    end else if (tmr_exp || tmr_zero) begin
      tmr_load = 1'b1;
      case (state)
        S_FILL: begin
          if (phase == PH_RINSE) begin
            state_nxt = S_RINSE;
            rinse_nxt = rinse_n + 2'd1;
            tmr_val   = RINSE_T;
          end else begin
            state_nxt = S_WASH;
            tmr_val   = WASH_T;
          end
        end
        S_WASH, S_RINSE: begin
          state_nxt = S_DRAIN;
          tmr_val   = DRAIN_T;
        end
        S_DRAIN: begin
          if (phase == PH_ABORT) begin
            state_nxt   = S_IDLE;
            phase_nxt   = PH_WASH;
            aborted_nxt = 1'b1;
            tmr_load    = 1'b0;
          end else if (phase == PH_WASH && dirty && wash_n < MAX_WASH_C) begin
            state_nxt = S_FILL;
            wash_nxt  = wash_n + CNT_W'(1);
            tmr_val   = fill_len(size_o);
          end else if ((phase == PH_WASH && rinse_l != '0) ||
                       (phase == PH_RINSE && rinse_n < rinse_l)) begin
            state_nxt = S_FILL;
            phase_nxt = PH_RINSE;
            tmr_val   = fill_len(size_o);
          end else begin
            state_nxt = S_DRY;
            tmr_val   = DRY_T;
          end
        end
        S_DRY: begin
          if (wet && ext_n < MAX_EXT_C) begin
            ext_nxt = ext_n + CNT_W'(1);
            tmr_val = DRY_T;
          end else begin
            state_nxt = S_DONE;
            tmr_load  = 1'b0;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          tmr_load  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state    <= S_IDLE;
      phase    <= PH_WASH;
      size_o   <= '0;
      rinse_l  <= '0;
      rinse_n  <= '0;
      wash_n   <= '0;
      ext_n    <= '0;
      act      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      bad_size <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      size_o   <= size_nxt;
      rinse_l  <= rinse_l_nxt;
      rinse_n  <= rinse_nxt;
      wash_n   <= wash_nxt;
      ext_n    <= ext_nxt;
      act      <= pause ? '0 : act_onehot(state_nxt);
      busy     <= (state_nxt != S_IDLE);
      done     <= (state_nxt == S_DONE);
      aborted  <= aborted_nxt;
      bad_size <= bad_nxt;
    end
  end

  assign fill  = act[ACT_FILL];
  assign wash  = act[ACT_WASH];
  assign rinse = act[ACT_RINSE];
  assign drain = act[ACT_DRAIN];
  assign dry   = act[ACT_DRY];

endmodule
